// File: rtl/tcdm_ecc_pkg.sv
// Shared widths and FSM state type for the SECDED-protected TCDM bank controller.
package tcdm_ecc_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned EncWidth  = 39;
  localparam int unsigned ProtWidth = 7;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_e;

endpackage

// File: rtl/ecc_sat_counter.sv
// Saturating event counter with synchronous clear that wins over increment.
module ecc_sat_counter #(
  parameter int unsigned width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc,
  input  logic             clr,
  output logic [width-1:0] count
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/prim_secded_39_32_dec.sv
// Hsiao (39,32) SECDED decoder: corrects one flipped data bit, flags double errors.
module prim_secded_39_32_dec (
  input  logic [38:0] data_i,
  output logic [31:0] data_o,
  output logic [6:0]  syndrome_o,
  output logic [1:0]  err_o
);

  localparam logic [31:0] ParityMask [7] = '{
    32'h2606BD25, 32'hDEBA8050, 32'h413D89AA, 32'h31234ED1,
    32'hC2C1323B, 32'h2DCC624C, 32'h98505586
  };

  always_comb begin
    logic [6:0] col;
    col = '0;
    for (int k = 0; k < 7; k++) begin
      syndrome_o[k] = data_i[32+k] ^ (^(data_i[31:0] & ParityMask[k]));
    end
    // A data bit is flipped only when the syndrome equals that bit's H-matrix column.
    for (int i = 0; i < 32; i++) begin
      for (int k = 0; k < 7; k++) begin
        col[k] = ParityMask[k][i];
      end
      data_o[i] = data_i[i] ^ (syndrome_o == col);
    end
    err_o[0] = ^syndrome_o;
    err_o[1] = ~err_o[0] & (|syndrome_o);
  end

endmodule

// File: rtl/prim_secded_39_32_enc.sv
// Hsiao (39,32) SECDED encoder: data in the low 32 bits, 7 check bits above.
module prim_secded_39_32_enc (
  input  logic [31:0] data_i,
  output logic [38:0] data_o
);

  localparam logic [31:0] ParityMask [7] = '{
    32'h2606BD25, 32'hDEBA8050, 32'h413D89AA, 32'h31234ED1,
    32'hC2C1323B, 32'h2DCC624C, 32'h98505586
  };

  always_comb begin
    data_o[31:0] = data_i;
    for (int k = 0; k < 7; k++) begin
      data_o[32+k] = ^(data_i & ParityMask[k]);
    end
  end

endmodule

// File: rtl/tcdm_ecc_bank_ctrl.sv
// Bank-side SECDED controller: full writes pass through, partial writes run RMW,
// reads return encoded data and scrub single-bit errors back into the SRAM.
module tcdm_ecc_bank_ctrl
  import tcdm_ecc_pkg::*;
#(
  parameter int unsigned MemAddrWidth       = 10,
  parameter bit          WriteBackCorrected = 1'b1,
  parameter int unsigned CntWidth           = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    tcdm_req_i,
  input  logic [31:0]             tcdm_add_i,
  input  logic                    tcdm_wen_i,
  input  logic [3:0]              tcdm_be_i,
  input  logic [EncWidth-1:0]     tcdm_wdata_i,
  output logic                    tcdm_gnt_o,
  output logic                    tcdm_r_valid_o,
  output logic [EncWidth-1:0]     tcdm_r_rdata_o,
  output logic                    tcdm_r_opc_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [MemAddrWidth-1:0] mem_addr_o,
  output logic [EncWidth-1:0]     mem_wdata_o,
  input  logic [EncWidth-1:0]     mem_rdata_i,
  output logic                    err_single_o,
  output logic                    err_double_o,
  input  logic                    cnt_clr_i,
  output logic [CntWidth-1:0]     corr_cnt_o,
  output logic [CntWidth-1:0]     uncorr_cnt_o
);

  state_e state_q, state_d;

  logic                    rd_pend_q, wr_rsp_q, opc_q, in_single_q;
  logic [MemAddrWidth-1:0] addr_q;
  logic [3:0]              be_q;
  logic [DataWidth-1:0]    wdata_q;

  logic [DataWidth-1:0]    in_data, mem_data, merged, enc_mem_in;
  logic [1:0]              in_err, mem_err;
  logic [ProtWidth-1:0]    in_syn, mem_syn;
  logic [EncWidth-1:0]     enc_wr_out, enc_mem_out;
  logic [MemAddrWidth-1:0] req_addr;

  logic accept, scrub, be_full, be_none, be_part;

  prim_secded_39_32_dec u_dec_in (
    .data_i     (tcdm_wdata_i),
    .data_o     (in_data),
    .syndrome_o (in_syn),
    .err_o      (in_err)
  );

  prim_secded_39_32_dec u_dec_mem (
    .data_i     (mem_rdata_i),
    .data_o     (mem_data),
    .syndrome_o (mem_syn),
    .err_o      (mem_err)
  );

  prim_secded_39_32_enc u_enc_wr (
    .data_i (in_data),
    .data_o (enc_wr_out)
  );

  prim_secded_39_32_enc u_enc_mem (
    .data_i (enc_mem_in),
    .data_o (enc_mem_out)
  );

  assign req_addr = tcdm_add_i[MemAddrWidth+1:2];
  assign be_full  = (tcdm_be_i == 4'hF);
  assign be_none  = (tcdm_be_i == 4'h0);
  assign be_part  = !be_full && !be_none;

  // The scrub write needs the mem port, so it is the one cycle a request is refused in IDLE.
  assign scrub  = rd_pend_q && mem_err[0] && WriteBackCorrected;
  assign accept = (state_q == IDLE) && tcdm_req_i && !scrub;

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = be_q[b] ? wdata_q[8*b +: 8] : mem_data[8*b +: 8];
    end
  end

  assign enc_mem_in = (state_q == MERGE) ? merged : mem_data;

  logic unused_bits;
  assign unused_bits = ^{tcdm_add_i[31:MemAddrWidth+2], tcdm_add_i[1:0], in_syn, mem_syn};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept && !tcdm_wen_i && be_part && !in_err[1]) state_d = MERGE;
      MERGE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_pend_q <= 1'b0;
      wr_rsp_q  <= 1'b0;
      opc_q     <= 1'b0;
    end else begin
      rd_pend_q <= accept && tcdm_wen_i;
      wr_rsp_q  <= accept && !tcdm_wen_i && (be_full || be_none || (be_part && in_err[1]));
      opc_q     <= accept && !tcdm_wen_i && !be_none && in_err[1];
    end
  end

  // NOTE: payload registers carry no reset; they are only consumed behind flags that are reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      addr_q      <= req_addr;
      be_q        <= tcdm_be_i;
      wdata_q     <= in_data;
      in_single_q <= in_err[0];
    end
  end

  // NOTE: every output gets a default first, so no path through the case can infer a latch.
  always_comb begin
    tcdm_gnt_o     = 1'b0;
    tcdm_r_valid_o = 1'b0;
    tcdm_r_rdata_o = '0;
    tcdm_r_opc_o   = 1'b0;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    err_single_o   = 1'b0;
    err_double_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        tcdm_gnt_o = tcdm_req_i && !scrub;
        if (rd_pend_q) begin
          tcdm_r_valid_o = 1'b1;
          tcdm_r_rdata_o = mem_rdata_i;
          tcdm_r_opc_o   = mem_err[1];
          err_single_o   = mem_err[0];
          err_double_o   = mem_err[1];
          if (scrub) begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = addr_q;
            mem_wdata_o = enc_mem_out;
          end
        end
        if (wr_rsp_q) begin
          tcdm_r_valid_o = 1'b1;
          tcdm_r_opc_o   = opc_q;
        end
        if (accept) begin
          if (tcdm_wen_i) begin
            mem_req_o  = 1'b1;
            mem_addr_o = req_addr;
          end else if (be_full) begin
            err_single_o = err_single_o || in_err[0];
            err_double_o = err_double_o || in_err[1];
            if (!in_err[1]) begin
              mem_req_o   = 1'b1;
              mem_we_o    = 1'b1;
              mem_addr_o  = req_addr;
              mem_wdata_o = enc_wr_out;
            end
          end else if (be_part) begin
            // An incoming single error is reported from MERGE so one transaction pulses once.
            if (in_err[1]) begin
              err_double_o = 1'b1;
            end else begin
              mem_req_o  = 1'b1;
              mem_addr_o = req_addr;
            end
          end
        end
      end
      MERGE: begin
        mem_req_o      = 1'b1;
        mem_we_o       = 1'b1;
        mem_addr_o     = addr_q;
        mem_wdata_o    = enc_mem_out;
        tcdm_r_valid_o = 1'b1;
        tcdm_r_opc_o   = mem_err[1];
        err_single_o   = in_single_q || mem_err[0];
        err_double_o   = mem_err[1];
      end
      default: ;
    endcase
  end

  ecc_sat_counter #(.width(CntWidth)) u_corr_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc    (err_single_o),
    .clr    (cnt_clr_i),
    .count  (corr_cnt_o)
  );

  ecc_sat_counter #(.width(CntWidth)) u_uncorr_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc    (err_double_o),
    .clr    (cnt_clr_i),
    .count  (uncorr_cnt_o)
  );

endmodule

// File: doc/tcdm_ecc_bank_ctrl.md
Name: tcdm_ecc_bank_ctrl

Overview:
- SRAM-bank-side controller directly downstream of the TCDM bus ECC encoder stage; accepts the 39-bit SECDED-encoded TCDM bus and drives one single-port 39-bit SRAM macro with 1-cycle read latency.
- Full-word writes pass through; partial (byte-enable) writes run as read-modify-write. Read data is returned still encoded for upstream decode.
- Single-bit errors found on reads are written back corrected (scrub-on-read). Corrected and uncorrectable events are counted.

Parameters:
- MemAddrWidth, 10: SRAM word-address width; mem_addr_o = tcdm_add_i[MemAddrWidth+1:2].
- WriteBackCorrected, 1: 1 = write back corrected word on a single-bit read error.
- CntWidth, 16: width of the saturating error counters.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- tcdm_req_i  in  1  request.
- tcdm_add_i  in  32  byte address.
- tcdm_wen_i  in  1  1 = read, 0 = write.
- tcdm_be_i  in  4  byte enables.
- tcdm_wdata_i  in  39  encoded write data.
- tcdm_gnt_o  out  1  grant.
- tcdm_r_valid_o  out  1  response valid.
- tcdm_r_rdata_o  out  39  encoded read data.
- tcdm_r_opc_o  out  1  1 = uncorrectable error.
- mem_req_o  out  1  SRAM request.
- mem_we_o  out  1  SRAM write enable.
- mem_addr_o  out  MemAddrWidth  SRAM word address.
- mem_wdata_o  out  39  SRAM write data.
- mem_rdata_i  in  39  SRAM read data, valid 1 cycle after a read request.
- err_single_o  out  1  1-cycle pulse: corrected error.
- err_double_o  out  1  1-cycle pulse: uncorrectable error.
- cnt_clr_i  in  1  synchronous clear of both counters.
- corr_cnt_o  out  CntWidth  saturating count of corrected errors.
- uncorr_cnt_o  out  CntWidth  saturating count of uncorrectable errors.

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; counters 0; response pipeline flags cleared.
- FSM states are IDLE and MERGE.
- IDLE: tcdm_gnt_o = tcdm_req_i, except during a scrub cycle (see below).
- Read accepted in IDLE: mem read is issued the same cycle. Next cycle: r_valid = 1, r_rdata = mem_rdata_i unmodified. Stay in IDLE; back-to-back reads run at 1 per cycle.
- Read response cycle, single-bit error with WriteBackCorrected = 1:
  - The mem port is used for the corrected re-encoded write to the latched address.
  - tcdm_gnt_o = 0 that cycle. This is the only combinational path from mem_rdata_i to tcdm_gnt_o.
  - err_single_o pulses.
- Read response cycle, double error: r_opc = 1, err_double_o pulses, no writeback.
- Full write (be = 4'hF) in IDLE: decode tcdm_wdata_i.
  - Clean or single error: write the re-encoded corrected word the same cycle. A single error also pulses err_single_o.
  - Double error: suppress the write, r_opc = 1, err_double_o pulses.
  - r_valid follows 1 cycle after grant.
- Write with be = 0: granted, no SRAM access, r_valid next cycle.
- Partial write (be ≠ 0, ≠ F) in IDLE:
  - Grant, issue an SRAM read, latch address, be and decoded wdata. Go to MERGE.
  - A double error in tcdm_wdata_i cancels the RMW: no SRAM read, r_valid next cycle with r_opc = 1.
- MERGE (exactly 1 cycle):
  - tcdm_gnt_o = 0.
  - Decode mem_rdata_i and correct a single error if present.
  - Merge enabled bytes from the latched data, re-encode, write to SRAM.
  - r_valid = 1. Return to IDLE.
  - Double error in old data: merge the uncorrected old bytes, still write, r_opc = 1, err_double_o pulses.
- Errors on both incoming and old data in one transaction produce a single pulse per type.
  - Counters increment by at most 1 per cycle per type.
- Counters saturate at all-ones. cnt_clr_i takes priority over an increment in the same cycle.
- Reset mid-MERGE: return to IDLE, no SRAM write, no r_valid.

Decomposition:
- Package tcdm_ecc_pkg holds: DataWidth = 32, EncWidth = 39, ProtWidth = 7, and the state_e enum {IDLE, MERGE}.
- Reuse the existing prim_secded_39_32_enc and prim_secded_39_32_dec primitives.
- One sub-module: ecc_sat_counter (parameter width, inc, clr, count), instantiated twice.

Test Plan:
- Full write 0xDEADBEEF to addr 0x40, then read 0x40 → r_valid 1 cycle after each grant; decoded rdata 0xDEADBEEF; r_opc 0; no error pulses.
- Memory model flips bit 5 of the stored word, then read → raw word returned; err_single_o pulse; gnt low in the response cycle; corrected word rewritten; corr_cnt_o = 1; a re-read is clean.
- Base 0x11223344, partial write be = 4'b0010 with data 0x0000AA00 → gnt low during MERGE; stored word decodes to 0x1122AA44.
- Flip bits 3 and 17 of the stored word, then read → r_opc = 1; err_double_o pulse; no SRAM write; uncorr_cnt_o = 1.
- Drive the corrected counter from 0xFFFE with 3 errors → holds at 0xFFFF; cnt_clr_i asserted with a coincident error → 0.
- Assert rst_ni low during MERGE → no mem_req_o, outputs 0, next request served normally from IDLE.
